// File: rtl/fpga_config_loader.sv
// Serial MSB-first bitstream receiver that assembles configuration rows and writes
// them one at a time into the fabric core, then releases ff_en and rdy.
module fpga_config_loader #(
    parameter int CFG_W  = 224,
    parameter int ROWS   = 43,
    parameter int SETTLE = 10
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             bs_valid,
    input  logic             bs_data,
    input  logic             bs_last,
    output logic             bs_ready,
    output logic [CFG_W-1:0] configs_in,
    output logic [ROWS-1:0]  configs_en,
    output logic             ff_en,
    output logic             rdy,
    output logic             err
);

    localparam int BIT_W = $clog2(CFG_W);
    localparam int ROW_W = $clog2(ROWS);
    localparam int SET_W = $clog2(SETTLE + 1);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE - 1);
    localparam logic [ROWS-1:0]  ROW_ONE  = {{(ROWS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_SHIFT    = 3'd0,
        ST_LOAD     = 3'd1,
        ST_STROBE   = 3'd2,
        ST_WAIT_FF  = 3'd3,
        ST_WAIT_RDY = 3'd4,
        ST_DONE     = 3'd5,
        ST_ERR      = 3'd6
    } state_t;

    state_t             state_r;
    state_t             next_state_s;
    logic [CFG_W-1:0]   shift_r;
    logic [CFG_W-1:0]   configs_in_r;
    logic [ROWS-1:0]    configs_en_r;
    logic [BIT_W-1:0]   bit_cnt_r;
    logic [ROW_W-1:0]   row_cnt_r;
    logic [SET_W-1:0]   settle_cnt_r;
    logic               bs_ready_r;
    logic               ff_en_r;
    logic               rdy_r;
    logic               err_r;
    logic               xfer_s;
    logic               row_end_s;
    logic [CFG_W-1:0]   row_next_s;

    assign xfer_s     = bs_valid && bs_ready_r;
    assign row_end_s  = (bit_cnt_r == BIT_LAST);
    assign row_next_s = {shift_r[CFG_W-2:0], bs_data};

    assign bs_ready   = bs_ready_r;
    assign configs_in = configs_in_r;
    assign configs_en = configs_en_r;
    assign ff_en      = ff_en_r;
    assign rdy        = rdy_r;
    assign err        = err_r;

    // Next-state decode including bitstream framing checks.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_SHIFT: begin
                if (xfer_s && row_end_s) begin
                    if (row_cnt_r == ROW_LAST) begin
                        next_state_s = bs_last ? ST_LOAD : ST_ERR;
                    end else begin
                        next_state_s = bs_last ? ST_ERR : ST_LOAD;
                    end
                end else if (xfer_s && bs_last) begin
                    next_state_s = ST_ERR;
                end else begin
                    next_state_s = ST_SHIFT;
                end
            end
            ST_LOAD:     next_state_s = ST_STROBE;
            ST_STROBE:   next_state_s = (row_cnt_r == ROW_LAST) ? ST_WAIT_FF : ST_SHIFT;
            ST_WAIT_FF:  next_state_s = (settle_cnt_r == SET_LAST) ? ST_WAIT_RDY : ST_WAIT_FF;
            ST_WAIT_RDY: next_state_s = (settle_cnt_r == SET_LAST) ? ST_DONE : ST_WAIT_RDY;
            ST_DONE:     next_state_s = ST_DONE;
            ST_ERR:      next_state_s = ST_ERR;
            default:     next_state_s = ST_ERR;
        endcase
    end

    // State register and registered handshake/status outputs, decoded from the next state.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_SHIFT;
            bs_ready_r   <= 1'b0;
            configs_en_r <= {ROWS{1'b0}};
            ff_en_r      <= 1'b0;
            rdy_r        <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            bs_ready_r   <= (next_state_s == ST_SHIFT);
            configs_en_r <= (next_state_s == ST_STROBE) ? (ROW_ONE << row_cnt_r) : {ROWS{1'b0}};
            ff_en_r      <= (next_state_s == ST_WAIT_RDY) || (next_state_s == ST_DONE);
            rdy_r        <= (next_state_s == ST_DONE);
            err_r        <= (next_state_s == ST_ERR);
        end
    end

    // Row assembly, row output register and the bit/row/settle counters.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            shift_r      <= {CFG_W{1'b0}};
            configs_in_r <= {CFG_W{1'b0}};
            bit_cnt_r    <= {BIT_W{1'b0}};
            row_cnt_r    <= {ROW_W{1'b0}};
            settle_cnt_r <= {SET_W{1'b0}};
        end else begin
            if (xfer_s) begin
                shift_r   <= row_next_s;
                bit_cnt_r <= row_end_s ? {BIT_W{1'b0}} : bit_cnt_r + BIT_W'(1);
            end else begin
                shift_r   <= shift_r;
                bit_cnt_r <= bit_cnt_r;
            end
            // Row data is captured on entry to LOAD so it is already stable a cycle before the strobe.
            if ((state_r == ST_SHIFT) && (next_state_s == ST_LOAD)) begin
                configs_in_r <= row_next_s;
            end else begin
                configs_in_r <= configs_in_r;
            end
            if ((state_r == ST_STROBE) && (row_cnt_r != ROW_LAST)) begin
                row_cnt_r <= row_cnt_r + ROW_W'(1);
            end else begin
                row_cnt_r <= row_cnt_r;
            end
            // Counts cycles since the reference event: 1 during the cycle after the strobe, 0 on ff_en rise.
            case (state_r)
                ST_STROBE:   settle_cnt_r <= SET_W'(1);
                ST_WAIT_FF,
                ST_WAIT_RDY: settle_cnt_r <= (settle_cnt_r == SET_LAST) ? {SET_W{1'b0}}
                                                                         : settle_cnt_r + SET_W'(1);
                default:     settle_cnt_r <= {SET_W{1'b0}};
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Scoreboard bench for fpga_config_loader: the driver queues expected row writes,
// a negedge monitor pops them on every configs_en strobe and checks timing.
module tb_fpga_config_loader;

    localparam int CFG_W  = 224;
    localparam int ROWS   = 43;
    localparam int SETTLE = 10;

    logic             clock = 1'b0;
    logic             rst = 1'b0;
    logic             bs_valid = 1'b0;
    logic             bs_data = 1'b0;
    logic             bs_last = 1'b0;
    logic             bs_ready;
    logic [CFG_W-1:0] configs_in;
    logic [ROWS-1:0]  configs_en;
    logic             ff_en;
    logic             rdy;
    logic             err;

    fpga_config_loader #(.CFG_W(CFG_W), .ROWS(ROWS), .SETTLE(SETTLE)) dut (
        .clock(clock), .rst(rst), .bs_valid(bs_valid), .bs_data(bs_data), .bs_last(bs_last),
        .bs_ready(bs_ready), .configs_in(configs_in), .configs_en(configs_en),
        .ff_en(ff_en), .rdy(rdy), .err(err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int               row;
        logic [CFG_W-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   stream_abort = 1'b0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    // Expected row r: the row index as a byte, replicated across the row.
    function automatic logic [CFG_W-1:0] row_val(input int r);
        logic [CFG_W-1:0] v;
        logic [7:0]       b;
        b = 8'(r);
        v = '0;
        for (int i = 0; i < CFG_W / 8; i++) v[i*8 +: 8] = b;
        return v;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    int               cyc = 0;
    int               last_strobe = -1;
    int               ff_rise = -1;
    logic             prev_ready = 1'b0;
    logic             prev_ff = 1'b0;
    logic             prev_rdy = 1'b0;
    logic [ROWS-1:0]  prev_en = '0;
    logic [CFG_W-1:0] prev_cfg = '0;
    exp_t             mon_e;

    always @(negedge clock) begin
        if (!rst) begin
            last_strobe = -1;
            ff_rise     = -1;
            prev_ready  = 1'b0;
            prev_ff     = 1'b0;
            prev_rdy    = 1'b0;
            prev_en     = '0;
            prev_cfg    = '0;
        end else begin
            cyc++;
            if (configs_en != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected strobe", 256'(configs_en), 256'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("strobe index", 256'(configs_en), 256'(ROWS'(1) << mon_e.row));
                    chk("row data", 256'(configs_in), 256'(mon_e.data));
                end
                chk("row stable before strobe", 256'(configs_in), 256'(prev_cfg));
                chk("bs_ready low in LOAD/STROBE", 256'({prev_ready, bs_ready}), 256'd0);
                last_strobe = cyc;
            end
            if (prev_en != '0) chk("row stable after strobe", 256'(configs_in), 256'(prev_cfg));
            if (ff_en && !prev_ff) begin
                chk("ff_en delay after last strobe", 256'(cyc - last_strobe), 256'(SETTLE));
                ff_rise = cyc;
            end
            if (rdy && !prev_rdy) chk("rdy delay after ff_en", 256'(cyc - ff_rise), 256'(SETTLE));
            prev_ready = bs_ready;
            prev_ff    = ff_en;
            prev_rdy   = rdy;
            prev_en    = configs_en;
            prev_cfg   = configs_in;
        end
    end

    // ---------------- driver ----------------
    task automatic drive_bit(input logic d, input logic l);
        int waited = 0;
        do begin
            @(negedge clock);
            bs_valid = 1'b1;
            bs_data  = d;
            bs_last  = l;
            waited++;
        end while (!bs_ready && waited < 1000);
        if (!bs_ready) begin
            chk("bs_ready timeout", 256'(bs_ready), 256'd1);
            stream_abort = 1'b1;
        end
    endtask

    task automatic send_stream(input int last_row, input int last_bit, input bit with_last,
                               input bit gaps, input int push_rows);
        logic [CFG_W-1:0] v;
        exp_t             e;
        stream_abort = 1'b0;
        for (int r = 0; r <= last_row && !stream_abort; r++) begin
            v = row_val(r);
            if (r < push_rows) begin
                e.row  = r;
                e.data = v;
                exp_q.push_back(e);
            end
            for (int k = 0; k < ((r == last_row) ? last_bit + 1 : CFG_W) && !stream_abort; k++) begin
                if (gaps && ($urandom_range(1, 0) == 1)) begin
                    repeat ($urandom_range(3, 1)) begin
                        @(negedge clock);
                        bs_valid = 1'b0;
                        bs_data  = 1'($urandom);
                        bs_last  = 1'($urandom);
                    end
                end
                drive_bit(v[CFG_W-1-k], with_last && (r == last_row) && (k == last_bit));
            end
        end
        @(negedge clock);
        bs_valid = 1'b0;
        bs_last  = 1'b0;
    endtask

    task automatic release_reset();
        @(negedge clock);
        rst = 1'b1;
        chk("bs_ready at release", 256'(bs_ready), 256'd0);
        @(negedge clock);
        chk("bs_ready one cycle after release", 256'(bs_ready), 256'd1);
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, " bs_ready"}, 256'(bs_ready), 256'd0);
        chk({tag, " configs_in"}, 256'(configs_in), 256'd0);
        chk({tag, " configs_en"}, 256'(configs_en), 256'd0);
        chk({tag, " ff_en/rdy/err"}, 256'({ff_en, rdy, err}), 256'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        rst      = 1'b0;
        bs_valid = 1'b0;
        @(negedge clock);
        check_cleared("reset");
        exp_q.delete();
        release_reset();
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 4 * SETTLE + 8 && !rdy; i++) @(negedge clock);
        chk({tag, " rdy"}, 256'(rdy), 256'd1);
        chk({tag, " ff_en/err"}, 256'({ff_en, err}), 256'b10);
        chk({tag, " rows outstanding"}, 256'(exp_q.size()), 256'd0);
    endtask

    task automatic check_error_hold(input string tag);
        repeat (40) @(negedge clock);
        chk({tag, " err/ff_en/rdy"}, 256'({err, ff_en, rdy}), 256'b100);
        chk({tag, " bs_ready"}, 256'(bs_ready), 256'd0);
        chk({tag, " rows outstanding"}, 256'(exp_q.size()), 256'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check_cleared("initial reset");
        release_reset();

        // Full load, continuous valid
        send_stream(ROWS - 1, CFG_W - 1, 1'b1, 1'b0, ROWS);
        wait_done("full load");

        // Extra traffic after completion is ignored
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk("done bs_ready", 256'(bs_ready), 256'd0);
            chk("done configs_en", 256'(configs_en), 256'd0);
            chk("done configs_in", 256'(configs_in), 256'(row_val(ROWS - 1)));
            chk("done ff_en/rdy/err", 256'({ff_en, rdy, err}), 256'b110);
            bs_valid = 1'b1;
            bs_data  = 1'($urandom);
            bs_last  = 1'($urandom);
        end
        bs_valid = 1'b0;

        // Same stream with random valid gaps
        do_reset();
        send_stream(ROWS - 1, CFG_W - 1, 1'b1, 1'b1, ROWS);
        wait_done("gapped load");

        // Premature bs_last on bit 5 of row 2
        do_reset();
        send_stream(2, 5, 1'b1, 1'b0, 2);
        chk("early last err next cycle", 256'(err), 256'd1);
        check_error_hold("early last");

        // bs_last withheld on the final bit
        do_reset();
        send_stream(ROWS - 1, CFG_W - 1, 1'b0, 1'b0, ROWS - 1);
        chk("missing last err", 256'(err), 256'd1);
        check_error_hold("missing last");

        // Asynchronous reset in the middle of row 10, then a clean reload
        do_reset();
        send_stream(10, 99, 1'b0, 1'b0, 10);
        chk("rows 0-9 written before abort", 256'(exp_q.size()), 256'd0);
        @(posedge clock);
        #2;
        rst = 1'b0;
        #1;
        check_cleared("async reset");
        exp_q.delete();
        release_reset();
        send_stream(ROWS - 1, CFG_W - 1, 1'b1, 1'b0, ROWS);
        wait_done("reload after abort");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
